// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_nibble.sv
// Combinational 4-bit ripple slice; exposes the carry into bit 3 so the
// controller can derive signed overflow on the most significant nibble.
module addsub_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fa
    assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = c[4];
  assign c3   = c[3];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Wide add/subtract performed one nibble per cycle through a single 4-bit
// slice, least-significant nibble first, with valid/ready on both sides.
module addsub_seq_ctrl
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_s,
  output logic                   out_c,
  output logic                   out_v,
  output logic                   out_z
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic          cy_reg;
  logic          op_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-5:0]  acc_reg;

  logic          sub;
  logic [3:0]    sl_a;
  logic [3:0]    sl_b;
  logic [3:0]    sl_s;
  logic          sl_cout;
  logic          sl_c3;
  logic [W-1:0]  final_s;

  assign sub     = (op_reg == OP_SUB);
  assign sl_a    = a_reg[{cnt_reg, 2'b00} +: 4];
  assign sl_b    = b_reg[{cnt_reg, 2'b00} +: 4] ^ {4{sub}};
  // Top nibble comes straight from the slice on the final RUN cycle.
  assign final_s = {sl_s, acc_reg};

  addsub_nibble u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (cy_reg),
    .s    (sl_s),
    .cout (sl_cout),
    .c3   (sl_c3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_s     <= '0;
      out_c     <= 1'b0;
      out_v     <= 1'b0;
      out_z     <= 1'b0;
      cnt_reg   <= '0;
      cy_reg    <= 1'b0;
      op_reg    <= OP_ADD;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            op_reg    <= in_op;
            cnt_reg   <= '0;
            cy_reg    <= (in_op != OP_ADD);
            in_ready  <= 1'b0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          cy_reg <= sl_cout;
          if (cnt_reg == LAST) begin
            out_s     <= final_s;
            out_c     <= sl_cout ^ sub;
            out_v     <= sl_cout ^ sl_c3;
            out_z     <= (final_s == '0);
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else begin
            acc_reg[{cnt_reg, 2'b00} +: 4] <= sl_s;
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Randomized and directed bench for addsub_seq_ctrl with a transaction-level
// reference model checked against the DUT on every falling clock edge.
module tb_addsub_seq_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_s;
  logic         out_c;
  logic         out_v;
  logic         out_z;

  int tests = 0;
  int fails = 0;
  int txn_no = 0;

  addsub_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_c     (out_c),
    .out_v     (out_v),
    .out_z     (out_z)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: plain integer add/subtract with textbook flag rules.
  function automatic res_t model_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    res_t r;
    logic [W:0] full;
    if (!op) begin
      full = {1'b0, a} + {1'b0, b};
      r.s  = full[W-1:0];
      r.c  = full[W];
      r.v  = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
    end else begin
      r.s  = a - b;
      r.c  = (a < b);
      r.v  = (a[W-1] != b[W-1]) && (r.s[W-1] != a[W-1]);
    end
    r.z = (r.s == '0);
    return r;
  endfunction

  // Transaction-level timing model: accept when ready, result NIB cycles later.
  logic m_ready = 1'b1;
  logic m_valid = 1'b0;
  int   m_cnt   = 0;
  res_t m_out   = '0;
  res_t m_pend  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_cnt   <= 0;
      m_out   <= '0;
    end else if (m_ready) begin
      if (in_valid) begin
        m_pend  <= model_op(in_a, in_b, in_op);
        m_ready <= 1'b0;
        m_cnt   <= NIB;
      end
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_valid <= 1'b1;
        m_out   <= m_pend;
      end
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
      m_ready <= 1'b1;
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, m_ready);
    check("out_valid", out_valid, m_valid);
    check("out_s", out_s, m_out.s);
    check("out_c", out_c, m_out.c);
    check("out_v", out_v, m_out.v);
    check("out_z", out_z, m_out.z);
  end

  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                        input int hold, input logic noise,
                        input logic [W-1:0] na, input logic [W-1:0] nb, output res_t r);
    int guard;
    int lat;
    r = '0;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1; out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = noise;
    if (noise) begin
      in_a = na; in_b = nb; in_op = ~op;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", lat, NIB);
    r = {out_s, out_c, out_v, out_z};
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ready_after_release", in_ready, 1'b1);
    txn_no++;
    $display("[TB] txn %0d: %h %s %h -> s=%h c=%0d v=%0d z=%0d lat=%0d hold=%0d",
             txn_no, a, op ? "-" : "+", b, r.s, r.c, r.v, r.z, lat, hold);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_ready", in_ready, 1'b1);
    check("reset_valid", out_valid, 1'b0);

    do_txn(16'h1234, 16'h0FCD, 1'b0, 0, 1'b0, '0, '0, r);
    check("add_s", r.s, 16'h2201); check("add_c", r.c, 0);
    check("add_v", r.v, 0);        check("add_z", r.z, 0);

    do_txn(16'h0005, 16'h0007, 1'b1, 1, 1'b1, 16'hAAAA, 16'h5555, r);
    check("sub_s", r.s, 16'hFFFE); check("sub_c", r.c, 1);
    check("sub_v", r.v, 0);        check("sub_z", r.z, 0);

    do_txn(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, '0, '0, r);
    check("ovf_add_s", r.s, 16'h8000); check("ovf_add_v", r.v, 1); check("ovf_add_c", r.c, 0);

    do_txn(16'h8000, 16'h0001, 1'b1, 0, 1'b0, '0, '0, r);
    check("ovf_sub_s", r.s, 16'h7FFF); check("ovf_sub_v", r.v, 1); check("ovf_sub_c", r.c, 0);

    do_txn(16'hFFFF, 16'h0001, 1'b0, 2, 1'b0, '0, '0, r);
    check("wrap_s", r.s, 16'h0000); check("wrap_c", r.c, 1);
    check("wrap_v", r.v, 0);        check("wrap_z", r.z, 1);

    // Backpressure: new operands presented throughout DONE, then accepted.
    do_txn(16'h4321, 16'h1234, 1'b1, 5, 1'b1, 16'h0A0A, 16'h0505, r);
    check("bp_s", r.s, 16'h30ED); check("bp_c", r.c, 0);
    do_txn(16'h0A0A, 16'h0505, 1'b0, 0, 1'b0, '0, '0, r);
    check("bp_next_s", r.s, 16'h0F0F);

    // Reset during the second RUN cycle.
    in_a = 16'h4444; in_b = 16'h1111; in_op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_valid", out_valid, 1'b0);
    check("midrun_rst_ready", in_ready, 1'b1);
    check("midrun_rst_s", out_s, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_txn(16'h1111, 16'h2222, 1'b0, 0, 1'b0, '0, '0, r);
    check("post_rst_s", r.s, 16'h3333); check("post_rst_c", r.c, 0);

    for (int i = 0; i < 40; i++) begin
      do_txn(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             W'($urandom), W'($urandom), r);
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
